// File: rtl/scalar_mem_access_unit.sv
// scalar_mem_access_unit
//   Load/store sequencer in front of a word-addressed scalar data memory with a
//   synchronous read port. Accepts one request at a time (single word or a
//   LANES-word vector), walks consecutive word addresses one per cycle, gathers
//   load data into lanes, and returns a response on a valid/ready handshake.
//   Requests that would touch a word outside 0..MEM_DEPTH-1 are rejected with
//   o_rsp_err and never reach the memory.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_req_valid        request present
//   o_req_ready        unit can accept (high only when idle)
//   i_req_we           1 = store, 0 = load
//   i_req_vec          1 = LANES words, 0 = single word in lane 0
//   i_req_addr         base word address
//   i_req_wdata        store data, lane i at [i*DATA_W +: DATA_W]
//   o_rsp_valid        response present
//   i_rsp_ready        consumer accepts response
//   o_rsp_rdata        gathered load data, same lane packing
//   o_rsp_err          request was out of range, no access made
//   o_mem_we/a/wd      memory write enable, address, write data
//   i_mem_rd           memory read data, valid the cycle after o_mem_a is sampled

module scalar_mem_access_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LANES     = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic                    i_req_vec,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [LANES*DATA_W-1:0] i_req_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [LANES*DATA_W-1:0] o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_mem_we,
  output logic [ADDR_W-1:0]       o_mem_a,
  output logic [DATA_W-1:0]       o_mem_wd,
  input  logic [DATA_W-1:0]       i_mem_rd
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t                        r_state;
  logic                          r_we;
  logic [IDX_W-1:0]              r_last;
  logic [IDX_W-1:0]              r_cnt;
  logic [ADDR_W-1:0]             r_addr;
  logic [LANES-1:0][DATA_W-1:0]  r_wdata;
  logic [LANES-1:0][DATA_W-1:0]  r_rdata;
  logic                          r_req_ready;
  logic                          r_rsp_valid;
  logic                          r_rsp_err;
  logic                          r_mem_we;
  logic [ADDR_W-1:0]             r_mem_a;
  logic [DATA_W-1:0]             r_mem_wd;

  logic                          w_accept;
  logic [IDX_W-1:0]              w_req_last;
  logic [ADDR_W:0]               w_end_addr;
  logic                          w_range_err;
  logic [LANES-1:0][DATA_W-1:0]  w_req_lanes;
  logic [IDX_W-1:0]              w_next_idx;
  logic [IDX_W-1:0]              w_prev_idx;

  assign w_accept    = i_req_valid & r_req_ready;
  assign w_req_last  = i_req_vec ? IDX_W'(LANES - 1) : '0;
  assign w_req_lanes = i_req_wdata;
  assign w_next_idx  = r_cnt + 1'b1;
  assign w_prev_idx  = r_cnt - 1'b1;

  // Last touched address computed one bit wider so a wrap past the top of the
  // address space shows up as the carry bit instead of a small legal address.
  assign w_end_addr  = {1'b0, i_req_addr} + {{(ADDR_W + 1 - IDX_W){1'b0}}, w_req_last};
  assign w_range_err = w_end_addr[ADDR_W] | (w_end_addr >= (ADDR_W + 1)'(MEM_DEPTH));

  // Memory bus and response outputs are driven straight from registers so the
  // memory sees clean, glitch-free address/enable timing.
  // In ACCESS, the read data arriving this cycle belongs to the element issued
  // in the previous cycle (synchronous read), hence the capture into lane cnt-1;
  // DRAIN exists only to pick up the final element of a load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= i_req_we;
            r_last      <= w_req_last;
            r_addr      <= i_req_addr;
            r_wdata     <= w_req_lanes;
            r_rdata     <= '0;
            r_cnt       <= '0;
            if (w_range_err) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_mem_we <= i_req_we;
              r_mem_a  <= i_req_addr;
              r_mem_wd <= i_req_we ? w_req_lanes[0] : '0;
              r_state  <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          if (!r_we && (r_cnt != '0)) begin
            r_rdata[w_prev_idx] <= i_mem_rd;
          end
          if (r_cnt == r_last) begin
            r_mem_we <= 1'b0;
            r_mem_a  <= '0;
            r_mem_wd <= '0;
            if (r_we) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_cnt    <= w_next_idx;
            r_mem_a  <= r_addr + ADDR_W'(w_next_idx);
            r_mem_wd <= r_we ? r_wdata[w_next_idx] : '0;
          end
        end

        S_DRAIN: begin
          r_rdata[r_last] <= i_mem_rd;
          r_rsp_valid     <= 1'b1;
          r_state         <= S_RESP;
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_mem_we    = r_mem_we;
  assign o_mem_a     = r_mem_a;
  assign o_mem_wd    = r_mem_wd;

endmodule
